// File: rtl/vsfx_pkg.sv
// ---------------------------------------------------------------------------
// vsfx_pkg
// Shared definitions for the vector simple fixed-point unit (vsfx):
//   VR_W / VR_AW / CR6_W   vector register width, VR address width, CR6 width
//   vsfx_ins_e             vsfx instruction opcode encodings
//   vsfx_wb_entry_t        one writeback queue entry {addr, data, sat, cr6, cr6_we}
// ---------------------------------------------------------------------------
package vsfx_pkg;

  localparam int VR_W  = 128;
  localparam int VR_AW = 5;
  localparam int CR6_W = 4;

  // Opcode encodings of the vsfx 'ins' field.
  typedef enum logic [3:0] {
    INS_VADDUBM  = 4'd0,
    INS_VADDUBS  = 4'd1,
    INS_VSUBUBM  = 4'd2,
    INS_VSUBUBS  = 4'd3,
    INS_VAVGUB   = 4'd4,
    INS_VMAXUB   = 4'd5,
    INS_VMINUB   = 4'd6,
    INS_VCMPEQUB = 4'd7,
    INS_VCMPGTUB = 4'd8,
    INS_VAND     = 4'd9,
    INS_VOR      = 4'd10,
    INS_VXOR     = 4'd11
  } vsfx_ins_e;

  typedef struct packed {
    logic [VR_AW-1:0] addr;
    logic [VR_W-1:0]  data;
    logic             sat;
    logic [CR6_W-1:0] cr6;
    logic             cr6_we;
  } vsfx_wb_entry_t;

endpackage

// File: rtl/vsfx_wb_fifo.sv
// ---------------------------------------------------------------------------
// vsfx_wb_fifo
// Synchronous in-order FIFO of vsfx_wb_entry_t. The head entry is read
// straight from the storage registers so it stays stable until it is popped.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     enqueue request and entry (ignored when full or flushing)
//   pop           dequeue request (ignored when empty)
//   flush         empty the queue on the next edge; a same-cycle push is lost
//   head          oldest entry
//   full, empty   occupancy flags
// ---------------------------------------------------------------------------
module vsfx_wb_fifo
  import vsfx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  vsfx_wb_entry_t din,
  input  logic           pop,
  input  logic           flush,
  output vsfx_wb_entry_t head,
  output logic           full,
  output logic           empty
);

  localparam int PW = $clog2(DEPTH);

  vsfx_wb_entry_t mem_r [DEPTH];
  logic [PW-1:0]  rd_ptr_r;
  logic [PW-1:0]  wr_ptr_r;
  logic [PW:0]    count_r;
  logic           push_ok_s;
  logic           pop_ok_s;

  assign full  = (count_r == (PW+1)'(DEPTH));
  assign empty = (count_r == {(PW+1){1'b0}});
  assign head  = mem_r[rd_ptr_r];

  // Qualify requests against occupancy; a flush swallows any push.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (push && !full && !flush) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
    if (pop && !empty) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy count; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vsfx_wb.sv
// ---------------------------------------------------------------------------
// vsfx_wb
// Writeback stage of the vsfx unit. Results are queued in order and committed
// to the VR file under a ready/valid handshake; each commit folds its
// saturation flag into the sticky VSCR[SAT] and, for record forms, loads CR6.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   vrt_en, vrt, sat, cr6, cr6_we,    result from vsfx_top and its destination
//   vrt_addr
//   res_ready                         queue can accept a result
//   flush                             discard all queued results
//   wr_en, wr_addr, wr_data, wr_ready VR file write port
//   vscr_we, vscr_wsat                mtvscr write of VSCR[SAT]
//   vscr_sat, cr6_q                   architectural VSCR[SAT] and CR6
//   busy                              queue non-empty
// AW must equal vsfx_pkg::VR_AW since the queue entry carries a VR_AW address.
// ---------------------------------------------------------------------------
module vsfx_wb
  import vsfx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vrt_en,
  input  logic [VR_W-1:0]  vrt,
  input  logic             sat,
  input  logic [CR6_W-1:0] cr6,
  input  logic             cr6_we,
  input  logic [AW-1:0]    vrt_addr,
  output logic             res_ready,
  input  logic             flush,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [VR_W-1:0]  wr_data,
  input  logic             wr_ready,
  input  logic             vscr_we,
  input  logic             vscr_wsat,
  output logic             vscr_sat,
  output logic [CR6_W-1:0] cr6_q,
  output logic             busy
);

  vsfx_wb_entry_t din_s;
  vsfx_wb_entry_t head_s;
  logic           full_s;
  logic           empty_s;
  logic           push_s;
  logic           commit_s;
  logic           vscr_sat_r;
  logic [CR6_W-1:0] cr6_r;

  // Pack the incoming result into a queue entry.
  always_comb begin
    din_s        = '0;
    din_s.addr   = vrt_addr;
    din_s.data   = vrt;
    din_s.sat    = sat;
    din_s.cr6    = cr6;
    din_s.cr6_we = cr6_we;
  end

  // A result offered while the queue is full is simply not enqueued.
  assign push_s   = vrt_en && res_ready;
  assign commit_s = wr_en && wr_ready;

  vsfx_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (din_s),
    .pop   (commit_s),
    .flush (flush),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign res_ready = !full_s;
  assign wr_en     = !empty_s;
  assign busy      = !empty_s;
  assign wr_addr   = head_s.addr;
  assign wr_data   = head_s.data;
  assign vscr_sat  = vscr_sat_r;
  assign cr6_q     = cr6_r;

  // Sticky SAT: mtvscr is younger than any committing result, so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      vscr_sat_r <= 1'b0;
    end else if (vscr_we) begin
      vscr_sat_r <= vscr_wsat;
    end else if (commit_s && head_s.sat) begin
      vscr_sat_r <= 1'b1;
    end else begin
      vscr_sat_r <= vscr_sat_r;
    end
  end

  // CR6 loads only from committing record-form results.
  always_ff @(posedge clk) begin
    if (rst) begin
      cr6_r <= {CR6_W{1'b0}};
    end else if (commit_s && head_s.cr6_we) begin
      cr6_r <= head_s.cr6;
    end else begin
      cr6_r <= cr6_r;
    end
  end

endmodule

// File: tb/tb_vsfx_wb.sv
// ---------------------------------------------------------------------------
// tb_vsfx_wb
// Self-checking bench for vsfx_wb: a directed vector table, hand-written
// multi-cycle sequences (backpressure, flush, reset mid-stream) and a random
// phase, all checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_vsfx_wb;
  import vsfx_pkg::*;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst, vrt_en, sat, cr6_we, flush, wr_ready, vscr_we, vscr_wsat;
  logic [127:0] vrt;
  logic [3:0]   cr6;
  logic [4:0]   vrt_addr;
  logic         res_ready, wr_en, vscr_sat, busy;
  logic [4:0]   wr_addr;
  logic [127:0] wr_data;
  logic [3:0]   cr6_q;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: the in-order queue and the architectural bits.
  vsfx_wb_entry_t mq[$];
  logic           m_vscr;
  logic [3:0]     m_cr6;

  always #5 clk = ~clk;

  vsfx_wb #(.DEPTH(DEPTH), .AW(5)) dut (
    .clk(clk), .rst(rst), .vrt_en(vrt_en), .vrt(vrt), .sat(sat), .cr6(cr6),
    .cr6_we(cr6_we), .vrt_addr(vrt_addr), .res_ready(res_ready), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .vscr_we(vscr_we), .vscr_wsat(vscr_wsat), .vscr_sat(vscr_sat),
    .cr6_q(cr6_q), .busy(busy)
  );

  typedef struct {
    logic rst, ven; logic [4:0] addr; logic [127:0] data; logic sat;
    logic [3:0] cr6; logic cr6_we, flush, wrr, vwe, vws;
    logic e_wr_en; logic [4:0] e_addr; logic e_rr, e_busy, e_vscr; logic [3:0] e_cr6;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; vrt_en = 1'b0; vrt = 128'h0; sat = 1'b0; cr6 = 4'h0; cr6_we = 1'b0;
    vrt_addr = 5'd0; flush = 1'b0; wr_ready = 1'b0; vscr_we = 1'b0; vscr_wsat = 1'b0;
  endtask

  // Apply the currently driven inputs to the model as one clock edge.
  task automatic model_step();
    vsfx_wb_entry_t h;
    bit pop, push;
    if (rst) begin
      mq.delete();
      m_vscr = 1'b0;
      m_cr6  = 4'h0;
    end else begin
      pop  = (mq.size() != 0) && wr_ready;
      push = vrt_en && (mq.size() < DEPTH) && !flush;
      h    = '0;
      if (pop) h = mq.pop_front();
      if (vscr_we) m_vscr = vscr_wsat;
      else if (pop && h.sat) m_vscr = 1'b1;
      if (pop && h.cr6_we) m_cr6 = h.cr6;
      if (flush) mq.delete();
      else if (push) mq.push_back('{addr: vrt_addr, data: vrt, sat: sat, cr6: cr6, cr6_we: cr6_we});
    end
  endtask

  task automatic model_check();
    chk("wr_en", wr_en, mq.size() != 0);
    chk("busy", busy, mq.size() != 0);
    chk("res_ready", res_ready, mq.size() < DEPTH);
    chk("vscr_sat", vscr_sat, m_vscr);
    chk("cr6_q", cr6_q, m_cr6);
    if (mq.size() != 0) begin
      chk("wr_addr", wr_addr, mq[0].addr);
      chk("wr_data", wr_data, mq[0].data);
    end
  endtask

  // One clock: protocol check, edge, model update, sample 1 time unit later.
  task automatic tick();
    if (vrt_en && !rst) chk("push_while_ready", res_ready, 1'b1);
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic push_drv(input logic [4:0] a, input logic [127:0] d, input logic s,
                          input logic [3:0] c, input logic cw);
    vrt_en = 1'b1; vrt_addr = a; vrt = d; sat = s; cr6 = c; cr6_we = cw;
  endtask

  initial begin
    vec_t vt [8];
    logic [127:0] held;

    vt[0] = '{1'b1, 1'b0, 5'd0, 128'h0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'h0};
    vt[1] = '{1'b0, 1'b1, 5'd3, 128'h1,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 4'h0};
    vt[2] = '{1'b0, 1'b0, 5'd0, 128'h0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'h0};
    vt[3] = '{1'b0, 1'b1, 5'd5, 128'h55, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 4'h0};
    vt[4] = '{1'b0, 1'b1, 5'd6, 128'h66, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 4'h8};
    vt[5] = '{1'b0, 1'b0, 5'd0, 128'h0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 4'h8};
    vt[6] = '{1'b0, 1'b1, 5'd7, 128'h77, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 4'h8};
    vt[7] = '{1'b0, 1'b0, 5'd0, 128'h0,  1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'h8};

    clear_inputs();
    m_vscr = 1'b0;
    m_cr6  = 4'h0;

    // Directed table: reset, single result, sticky SAT, CR6, mtvscr priority.
    for (int i = 0; i < 8; i++) begin
      rst = vt[i].rst; vrt_en = vt[i].ven; vrt_addr = vt[i].addr; vrt = vt[i].data;
      sat = vt[i].sat; cr6 = vt[i].cr6; cr6_we = vt[i].cr6_we; flush = vt[i].flush;
      wr_ready = vt[i].wrr; vscr_we = vt[i].vwe; vscr_wsat = vt[i].vws;
      tick();
      chk($sformatf("vec%0d_wr_en", i), wr_en, vt[i].e_wr_en);
      chk($sformatf("vec%0d_res_ready", i), res_ready, vt[i].e_rr);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d_vscr_sat", i), vscr_sat, vt[i].e_vscr);
      chk($sformatf("vec%0d_cr6_q", i), cr6_q, vt[i].e_cr6);
      if (vt[i].e_wr_en) chk($sformatf("vec%0d_wr_addr", i), wr_addr, vt[i].e_addr);
      if (i == 0) begin
        chk("reset_wr_addr", wr_addr, 5'd0);
        chk("reset_wr_data", wr_data, 128'h0);
      end
    end

    // Backpressure: fill with wr_ready low, data holds, then drain in order.
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      push_drv(5'(i), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'h0, 1'b0);
      tick();
    end
    clear_inputs();
    chk("bp_full_res_ready", res_ready, 1'b0);
    held = wr_data;
    tick();
    tick();
    chk("bp_data_stable", wr_data, held);
    chk("bp_addr_stable", wr_addr, 5'd0);
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_order%0d", i), wr_addr, 5'(i));
      tick();
    end
    chk("bp_drained_busy", busy, 1'b0);

    // Flush: three queued, head commits with its sat/cr6, rest and push lost.
    clear_inputs();
    push_drv(5'd10, 128'hA, 1'b1, 4'h5, 1'b1); tick();
    push_drv(5'd11, 128'hB, 1'b0, 4'h6, 1'b1); tick();
    push_drv(5'd12, 128'hC, 1'b0, 4'h7, 1'b1); tick();
    push_drv(5'd20, 128'h20, 1'b0, 4'h9, 1'b1);
    wr_ready = 1'b1;
    flush    = 1'b1;
    tick();
    chk("flush_busy", busy, 1'b0);
    chk("flush_head_sat", vscr_sat, 1'b1);
    chk("flush_head_cr6", cr6_q, 4'h5);
    clear_inputs();
    tick();
    chk("flush_push_dropped", busy, 1'b0);

    // Reset mid-stream with two entries queued and SAT set.
    push_drv(5'd1, 128'h11, 1'b1, 4'h3, 1'b1); tick();
    push_drv(5'd2, 128'h22, 1'b1, 4'h4, 1'b1); tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 128'h0);
    chk("rst_vscr_sat", vscr_sat, 1'b0);
    chk("rst_cr6_q", cr6_q, 4'h0);
    chk("rst_res_ready", res_ready, 1'b1);
    rst = 1'b0;

    // Random traffic against the model; upstream honours res_ready.
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      if (($urandom % 3 != 0) && (mq.size() < DEPTH))
        push_drv(5'($urandom), {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom % 4 == 0), 4'($urandom), 1'($urandom));
      wr_ready  = ($urandom % 4 != 0);
      flush     = ($urandom % 50 == 0);
      vscr_we   = ($urandom % 20 == 0);
      vscr_wsat = 1'($urandom);
      rst       = ($urandom % 300 == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
